// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate formats
// and the registered control bundle handed to the execute stage.
package decode_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [4:0] rs1sel;
    logic [4:0] rs2sel;
    logic [4:0] rdsel;
    logic       enrd;
    logic [3:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       illegal;
  } decode_t;

  // alt selects SUB over ADD and SRA over SRL (funct7[5] / ins[30]).
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends the immediate
// field of the instruction for the requested format.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     ins_i,
  input  imm_type_e       imm_type_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (imm_type_i)
      IMM_I:   imm_o = XLEN'($signed(ins_i[31:20]));
      IMM_S:   imm_o = XLEN'($signed({ins_i[31:25], ins_i[11:7]}));
      IMM_B:   imm_o = XLEN'($signed({ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0}));
      IMM_U:   imm_o = XLEN'($signed({ins_i[31:12], 12'b0}));
      IMM_J:   imm_o = XLEN'($signed({ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0}));
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with RV32I decoder behind a valid/ready handshake.
// Optional DECODE_STALL_COUNT_EN adds a saturating stall_cnt output.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
`ifdef DECODE_STALL_COUNT_EN
  output logic [15:0]     stall_cnt,
`endif
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ins,
  input  logic [XLEN-1:0] pc_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1sel,
  output logic [4:0]      rs2sel,
  output logic [4:0]      rdsel,
  output logic            enrd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            writes_rd;
  imm_type_e       imm_type;
  decode_t         ctrl_d, ctrl_q;
  logic [XLEN-1:0] imm_d, imm_q, pc_q;
  logic            valid_q;
  logic            accept;

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  always_comb begin
    ctrl_d        = '0;
    ctrl_d.alu_op = ALU_ADD;
    imm_type      = IMM_NONE;
    writes_rd     = 1'b0;
    case (opcode)
      OP_LUI:    begin imm_type = IMM_U; ctrl_d.alu_op = ALU_PASS_B; writes_rd = 1'b1; end
      OP_AUIPC:  begin imm_type = IMM_U; writes_rd = 1'b1; end
      OP_JAL:    begin imm_type = IMM_J; ctrl_d.jump = 1'b1; writes_rd = 1'b1; end
      OP_JALR:   begin imm_type = IMM_I; ctrl_d.jump = 1'b1; writes_rd = 1'b1; end
      OP_BRANCH: begin
        imm_type       = IMM_B;
        ctrl_d.alu_op  = ALU_SUB;
        ctrl_d.branch  = 1'b1;
        ctrl_d.illegal = (funct3 == 3'b011);
      end
      OP_LOAD:   begin imm_type = IMM_I; ctrl_d.mem_rd = 1'b1; writes_rd = 1'b1; end
      OP_STORE:  begin imm_type = IMM_S; ctrl_d.mem_wr = 1'b1; end
      OP_IMM:    begin
        imm_type      = IMM_I;
        writes_rd     = 1'b1;
        ctrl_d.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OP_OP:     begin
        writes_rd      = 1'b1;
        ctrl_d.alu_op  = alu_from_funct3(funct3, funct7[5]);
        // funct7 0x20 is only meaningful for SUB and SRA.
        ctrl_d.illegal = !((funct7 == 7'h00) ||
                           ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_MISC_MEM, OP_SYSTEM: imm_type = IMM_I;
      default:   ctrl_d.illegal = 1'b1;
    endcase

    if (ctrl_d.illegal) begin
      ctrl_d.alu_op = ALU_ADD;
      ctrl_d.mem_rd = 1'b0;
      ctrl_d.mem_wr = 1'b0;
      ctrl_d.branch = 1'b0;
      ctrl_d.jump   = 1'b0;
      writes_rd     = 1'b0;
      imm_type      = IMM_NONE;
    end

    ctrl_d.rs1sel = ins[19:15];
    ctrl_d.rs2sel = ins[24:20];
    ctrl_d.rdsel  = ins[11:7];
    ctrl_d.enrd   = writes_rd && (ins[11:7] != 5'd0);
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ins_i      (ins[31:7]),
    .imm_type_i (imm_type),
    .imm_o      (imm_d)
  );

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pc_q    <= pc_in;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_q;
  assign imm       = imm_q;
  assign rs1sel    = ctrl_q.rs1sel;
  assign rs2sel    = ctrl_q.rs2sel;
  assign rdsel     = ctrl_q.rdsel;
  assign enrd      = ctrl_q.enrd;
  assign alu_op    = ctrl_q.alu_op;
  assign mem_rd    = ctrl_q.mem_rd;
  assign mem_wr    = ctrl_q.mem_wr;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign illegal   = ctrl_q.illegal;

`ifdef DECODE_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes reference-model decodes on
// accepted instructions, a monitor compares them as the stage presents them.
module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = '0;
  logic [31:0] pc_in = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, enrd, mem_rd, mem_wr, branch, jump, illegal;
  logic [31:0] pc_out, imm;
  logic [4:0]  rs1sel, rs2sel, rdsel;
  logic [3:0]  alu_op;
`ifdef DECODE_STALL_COUNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] expStall = '0;
`endif

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
`ifdef DECODE_STALL_COUNT_EN
    .stall_cnt (stall_cnt),
`endif
    .clk       (clk),
    .reset     (reset),
    .ins       (ins),
    .pc_in     (pc_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .pc_out    (pc_out),
    .rs1sel    (rs1sel),
    .rs2sel    (rs2sel),
    .rdsel     (rdsel),
    .enrd      (enrd),
    .imm       (imm),
    .alu_op    (alu_op),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .branch    (branch),
    .jump      (jump),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        enrd;
    logic [3:0]  alu;
    logic        memRd;
    logic        memWr;
    logic        br;
    logic        jmp;
    logic        ill;
  } expT;

  expT expQ[$];
  int  checkCount = 0;
  int  errorCount = 0;
  bit  checking = 1'b0;
  bit  shown = 1'b0;
  bit  expResetState = 1'b1;

  // Interpret a bits-wide two's-complement field as a 32-bit signed value.
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    if (v[bits-1]) return v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [3:0] aluRef(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic expT refDecode(input logic [31:0] i, input logic [31:0] pc);
    expT e;
    bit writes;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0;
    e.pc = pc;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd = i[11:7];
    e.alu = ALU_ADD;
    writes = 1'b0;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h37: begin e.imm = i & 32'hFFFF_F000; e.alu = ALU_PASS_B; writes = 1; end
      7'h17: begin e.imm = i & 32'hFFFF_F000; writes = 1; end
      7'h6F: begin
        e.imm = sx(i[31] * 32'h10_0000 + i[19:12] * 32'h1000 + i[20] * 32'h800 + i[30:21] * 32'd2, 21);
        e.jmp = 1; writes = 1;
      end
      7'h67: begin e.imm = sx({20'd0, i[31:20]}, 12); e.jmp = 1; writes = 1; end
      7'h63: begin
        e.imm = sx(i[31] * 32'h1000 + i[7] * 32'h800 + i[30:25] * 32'd32 + i[11:8] * 32'd2, 13);
        e.alu = ALU_SUB; e.br = 1; e.ill = (f3 == 3'd3);
      end
      7'h03: begin e.imm = sx({20'd0, i[31:20]}, 12); e.memRd = 1; writes = 1; end
      7'h23: begin e.imm = sx(i[31:25] * 32'd32 + i[11:7], 12); e.memWr = 1; end
      7'h13: begin e.imm = sx({20'd0, i[31:20]}, 12); e.alu = aluRef(f3, f3 == 3'd5 && i[30]); writes = 1; end
      7'h33: begin
        e.alu = aluRef(f3, f7 == 7'h20);
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        writes = 1;
      end
      7'h0F, 7'h73: e.imm = sx({20'd0, i[31:20]}, 12);
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.imm = '0; e.alu = ALU_ADD; e.memRd = 0; e.memWr = 0; e.br = 0; e.jmp = 0; writes = 0;
    end
    e.enrd = writes && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] genIns();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73;
      default: ;
    endcase
    if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One call per cycle; pushes the reference decode when the model says it is accepted.
  task automatic applyStimulus(input bit rst, input bit vld, input logic [31:0] insV,
                               input logic [31:0] pcV, input bit rdy, input bit fl);
    @(negedge clk);
    #1;
    reset = rst;
    in_valid = vld;
    ins = insV;
    pc_in = pcV;
    out_ready = rdy;
    flush = fl;
    if (!rst && !fl && vld && (!shown || rdy)) expQ.push_back(refDecode(insV, pcV));
  endtask

  // Monitor: one time unit before each rising edge, compare and retire.
  always begin
    expT e;
    @(negedge clk);
    #4;
    if (checking) begin
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !flush && (!shown || out_ready)});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, shown});
      if (shown) begin
        e = expQ[0];
        checkOutput("pc_out", pc_out, e.pc);
        checkOutput("imm", imm, e.imm);
        checkOutput("rs1sel", {27'd0, rs1sel}, {27'd0, e.rs1});
        checkOutput("rs2sel", {27'd0, rs2sel}, {27'd0, e.rs2});
        checkOutput("rdsel", {27'd0, rdsel}, {27'd0, e.rd});
        checkOutput("enrd", {31'd0, enrd}, {31'd0, e.enrd});
        checkOutput("alu_op", {28'd0, alu_op}, {28'd0, e.alu});
        checkOutput("ctrl", {27'd0, mem_rd, mem_wr, branch, jump, illegal},
                    {27'd0, e.memRd, e.memWr, e.br, e.jmp, e.ill});
      end else if (expResetState) begin
        checkOutput("reset_pc_out", pc_out, RST_PC);
        checkOutput("reset_imm", imm, 32'd0);
        checkOutput("reset_fields", {13'd0, rs1sel, rs2sel, rdsel, enrd, alu_op},
                    32'd0);
        checkOutput("reset_ctrl", {27'd0, mem_rd, mem_wr, branch, jump, illegal}, 32'd0);
      end
`ifdef DECODE_STALL_COUNT_EN
      checkOutput("stall_cnt", {16'd0, stall_cnt}, {16'd0, expStall});
`endif
    end
`ifdef DECODE_STALL_COUNT_EN
    if (reset) expStall = '0;
    else if (shown && !out_ready && expStall != 16'hFFFF) expStall = expStall + 16'd1;
`endif
    if (reset) begin
      expQ.delete();
      shown = 1'b0;
      expResetState = 1'b1;
    end else begin
      if (shown && (flush || out_ready)) begin
        void'(expQ.pop_front());
        shown = 1'b0;
      end
      if (!shown && expQ.size() != 0) begin
        shown = 1'b1;
        expResetState = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] directed [7];
    directed[0] = 32'h0050_0093;  // addi x1,x0,5
    directed[1] = 32'h0020_A423;  // sw x2,8(x1)
    directed[2] = 32'hFE00_0EE3;  // beq x0,x0,-4
    directed[3] = 32'h1234_52B7;  // lui x5,0x12345
    directed[4] = 32'h0000_0000;  // illegal
    directed[5] = 32'h0220_81B3;  // R-type funct7=0x01
    directed[6] = 32'h0000_0013;  // nop

    applyStimulus(1, 0, '0, '0, 1, 0);
    applyStimulus(1, 0, '0, '0, 1, 0);
    checking = 1'b1;

    foreach (directed[k]) applyStimulus(0, 1, directed[k], 32'h1000 + 32'(k) * 4, 1, 0);
    applyStimulus(0, 0, '0, '0, 1, 0);

    // Backpressure: three held cycles, then the waiting instruction goes in.
    applyStimulus(0, 1, 32'h0050_0093, 32'h2000, 1, 0);
    repeat (3) applyStimulus(0, 1, 32'h0020_A423, 32'h2004, 0, 0);
    applyStimulus(0, 1, 32'h0020_A423, 32'h2004, 1, 0);
    applyStimulus(0, 0, '0, '0, 1, 0);

    // Flush with a held instruction and a new one on the input.
    applyStimulus(0, 1, 32'h1234_52B7, 32'h3000, 1, 0);
    applyStimulus(0, 1, 32'hFE00_0EE3, 32'h3004, 0, 1);
    applyStimulus(0, 0, '0, '0, 1, 0);

    // Reset while holding.
    applyStimulus(0, 1, 32'h0050_0093, 32'h4000, 1, 0);
    repeat (2) applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(1, 1, 32'h0020_A423, 32'h4004, 0, 0);
    applyStimulus(0, 0, '0, '0, 1, 0);

    // Five stall cycles.
    applyStimulus(0, 1, 32'h0020_A423, 32'h5000, 1, 0);
    repeat (5) applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 1, 0);

    repeat (400) begin
      applyStimulus($urandom_range(0, 96) == 0, $urandom_range(0, 3) != 0, genIns(),
                    {$urandom, 2'b00} >> 2 << 2, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 12) == 0);
    end
    repeat (3) applyStimulus(0, 0, '0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
